// File: rtl/sipo_sched_pkg.sv
// Shared state encoding and width helper for the serial link scheduler.
package sipo_sched_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_rx_shift.sv
// WIDTH-stage receive shift register, filled MSB-side so an LSB-first stream lands in order.
// One bit per enabled cycle; no backpressure, the sequencer owns shift_en.
module sipo_rx_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] pout
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pout <= '0;
    end else if (shift_en) begin
      pout <= {sin, pout[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_link_sched.sv
// Arbitrates requesters onto the serial link, shifts the winner's word out and strobes it back in; request-to-valid WIDTH+1 edges.
// Requesters hold req until ack; SIPO_SCHED_RR_EN selects round-robin, otherwise lowest index wins.
module sipo_link_sched
  import sipo_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic                     ser_out,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  output logic [clog2(NREQ)-1:0]   pout_src
);

  localparam int SW = clog2(NREQ);
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_shreg, rx_shreg, pout_hold;
  logic [SW-1:0]    src, src_hold, win;
  logic             found, load, shift_en;

  assign load     = (state == ST_IDLE) && (|req);
  assign shift_en = (state == ST_SHIFT);

`ifdef SIPO_SCHED_RR_EN
  logic [SW-1:0] ptr;

  // Search begins just past the last winner so every requester gets a turn.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        win   = SW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= SW'(NREQ - 1);
    end else if (load) begin
      ptr <= win;
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        win   = SW'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    ser_out    = 1'b0;
    pout_valid = 1'b0;
    ack        = '0;
    pout       = pout_hold;
    pout_src   = src_hold;
    unique case (state)
      ST_IDLE: begin
        if (|req) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        ser_out = tx_shreg[0];
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        pout_valid = 1'b1;
        ack[src]   = 1'b1;
        pout       = rx_shreg;
        pout_src   = src;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // pout_hold keeps the delivered word visible once the receive register starts refilling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      tx_shreg  <= '0;
      grant     <= '0;
      src       <= '0;
      pout_hold <= '0;
      src_hold  <= '0;
    end else if (load) begin
      tx_shreg   <= data[int'(win)*WIDTH +: WIDTH];
      grant      <= '0;
      grant[win] <= 1'b1;
      src        <= win;
      cnt        <= '0;
    end else if (state == ST_SHIFT) begin
      tx_shreg <= tx_shreg >> 1;
      if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
    end else if (state == ST_DONE) begin
      grant     <= '0;
      pout_hold <= rx_shreg;
      src_hold  <= src;
    end
  end

  sipo_rx_shift #(.WIDTH(WIDTH)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .sin      (ser_out),
    .pout     (rx_shreg)
  );

endmodule

// File: tb/tb_sipo_link_sched.sv
// Scoreboard bench for sipo_link_sched: transaction model predicts loads, windows and delivered words.
module tb_sipo_link_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int SW    = 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       grant, ack;
  logic                  busy, ser_out, pout_valid;
  logic [WIDTH-1:0]      pout;
  logic [SW-1:0]         pout_src;

  always #5 clk = ~clk;

  sipo_link_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .grant      (grant),
    .ack        (ack),
    .busy       (busy),
    .ser_out    (ser_out),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_src   (pout_src)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    int               src;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  // Transaction model: one transfer occupies WIDTH+2 edges from its load edge.
  int               cyc = 0;
  bit               m_active = 1'b0;
  int               m_load = 0;
  int               m_src = 0;
  int               m_ptr = NREQ - 1;
  int               m_w;
  logic [WIDTH-1:0] m_word = '0;
  logic [WIDTH-1:0] last_word = '0;
  int               last_src = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active  = 1'b0;
      m_ptr     = NREQ - 1;
      last_word = '0;
      last_src  = 0;
      sb.delete();
    end else begin
      cyc++;
      if (m_active && cyc == m_load + WIDTH + 1) begin
        last_word = m_word;
        last_src  = m_src;
      end
      if ((!m_active || cyc >= m_load + WIDTH + 2) && req != '0) begin
        m_w = -1;
`ifdef SIPO_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++)
          if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
        m_ptr = m_w;
`else
        for (int i = 0; i < NREQ; i++)
          if (m_w < 0 && req[i]) m_w = i;
`endif
        m_active = 1'b1;
        m_load   = cyc;
        m_src    = m_w;
        m_word   = data[m_w*WIDTH +: WIDTH];
        sb.push_back('{m_word, m_w, cyc + WIDTH});
      end
    end
  end

  bit               mon_en = 1'b0;
  bit               shift_w, done_w;
  logic [NREQ-1:0]  e_grant, e_ack;
  logic [WIDTH-1:0] e_pout;
  logic             e_ser;
  int               e_src;
  int               valid_cnt = 0;
  logic [WIDTH-1:0] hist[$];
  int               hcyc[$];
  int               hsrc[$];
  exp_t             got;

  always @(negedge clk) begin
    if (mon_en) begin
      shift_w = m_active && cyc >= m_load && cyc < m_load + WIDTH;
      done_w  = m_active && cyc == m_load + WIDTH;
      e_grant = (shift_w || done_w) ? NREQ'(1 << m_src) : '0;
      e_ack   = done_w ? NREQ'(1 << m_src) : '0;
      e_ser   = shift_w ? m_word[cyc - m_load] : 1'b0;
      e_pout  = done_w ? m_word : last_word;
      e_src   = done_w ? m_src : last_src;
      check("busy", busy, shift_w || done_w);
      check("grant", grant, e_grant);
      check("ack", ack, e_ack);
      check("ser_out", ser_out, e_ser);
      check("pout_valid", pout_valid, done_w);
      check("pout", pout, e_pout);
      check("pout_src", pout_src, e_src);
      if (pout_valid) begin
        valid_cnt++;
        hist.push_back(pout);
        hcyc.push_back(cyc);
        hsrc.push_back(int'(pout_src));
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 1, 0);
        end else begin
          got = sb.pop_front();
          check("sb_word", pout, got.word);
          check("sb_src", pout_src, got.src);
          check("sb_cycle", cyc, got.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        $display("FAIL sb_timeout word=%0h due_cycle=%0d now=%0d", sb[0].word, sb[0].cyc, cyc);
        checks++;
        errors++;
        void'(sb.pop_front());
      end
    end
  end

  bit auto_drop = 1'b1;

  task automatic tick();
    @(negedge clk);
    if (auto_drop)
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_grant(input int bound);
    int n;
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < bound);
    if (grant == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant bound=%0d expired", bound);
    end
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin tick(); n++; end while ((req != '0 || busy) && n < bound);
    if (req != '0 || busy) begin
      checks++;
      errors++;
      $display("FAIL wait_done bound=%0d expired req=%0b busy=%0b", bound, req, busy);
    end
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ser_out"}, ser_out, 0);
    check({tag, "_pout"}, pout, 0);
    check({tag, "_pout_valid"}, pout_valid, 0);
    check({tag, "_pout_src"}, pout_src, 0);
  endtask

  logic [WIDTH-1:0] exp_seq[4];
  int               n0;

  initial begin
`ifdef SIPO_SCHED_RR_EN
    exp_seq = '{4'hA, 4'h5, 4'hA, 4'h5};
`else
    exp_seq = '{4'hA, 4'hA, 4'hA, 4'hA};
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single transfer of 4'h6 from requester 0.
    set_data(0, 4'h6);
    req[0] = 1'b1;
    wait_done(40);
    check("t1_pout", hist[$], 4'h6);
    check("t1_src", hsrc[$], 0);

    // Both requesters held continuously.
    auto_drop = 1'b0;
    set_data(0, 4'hA);
    set_data(1, 4'h5);
    n0 = hist.size();
    req = 2'b11;
    repeat (4 * (WIDTH + 2)) tick();
    req = '0;
    auto_drop = 1'b1;
    wait_done(40);
    check("t2_count", hist.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < hist.size()) begin
        check("t2_seq", hist[n0+k], exp_seq[k]);
        if (k > 0) check("t2_spacing", hcyc[n0+k] - hcyc[n0+k-1], WIDTH + 2);
      end
    end

    // Reset after the second shift edge discards the transfer.
    set_data(0, 4'h7);
    req[0] = 1'b1;
    wait_grant(20);
    tick();
    tick();
    n0 = valid_cnt;
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    check("t3_no_valid", valid_cnt - n0, 0);
    set_data(1, 4'h9);
    req[1] = 1'b1;
    wait_done(40);
    check("t3_pout", hist[$], 4'h9);
    check("t3_src", hsrc[$], 1);

    // Requester drops req after the first shift edge.
    set_data(0, 4'hB);
    req[0] = 1'b1;
    n0 = valid_cnt;
    wait_grant(20);
    tick();
    req[0] = 1'b0;
    wait_done(40);
    check("t4_once", valid_cnt - n0, 1);
    check("t4_pout", hist[$], 4'hB);

    // Data change after the load edge is ignored.
    set_data(0, 4'h3);
    req[0] = 1'b1;
    wait_grant(20);
    set_data(0, 4'hC);
    wait_done(40);
    check("t5_pout", hist[$], 4'h3);

    // A request arriving mid-shift waits for the next IDLE edge.
    set_data(0, 4'h1);
    req[0] = 1'b1;
    wait_grant(20);
    tick();
    set_data(1, 4'hE);
    req[1] = 1'b1;
    wait_done(60);
    check("t6_pout", hist[$], 4'hE);
    check("t6_src", hsrc[$], 1);
    check("t6_spacing", hcyc[$] - hcyc[hcyc.size()-2], WIDTH + 2);

    // Random traffic with data churn and early drops.
    for (int t = 0; t < 400; t++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_data(i, WIDTH'($urandom));
        end else if (grant[i] && $urandom_range(0, 2) == 0) begin
          set_data(i, WIDTH'($urandom));
        end
        if (grant[i] && busy && $urandom_range(0, 7) == 0) req[i] = 1'b0;
      end
    end
    wait_done(200);

    for (int n = 0; n < 50 && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain pending=%0d", sb.size());
    end
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
